// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Single outstanding request: req/addr/gnt handshake, then rvalid/rdata response.
interface fetch_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request feeding the fetch/decode register.
// Define FETCH_PERF_CNT_EN to build the instruction/bubble performance counters.
module fetch_stage #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fetch_stage_if.master        imem,
   input  logic                 stall_i,
   input  logic                 exec_br_taken_i,
   input  logic [31:0]          exec_br_target_i,
   output logic [31:0]          dec_instr_o,
   output logic [31:0]          dec_pc_o,
   output logic [31:0]          dec_pcplus_o,
   output logic [31:0]          perf_instr_cnt_o,
   output logic [31:0]          perf_bubble_cnt_o
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        hold_valid_q, hold_valid_d;

   logic        req;
   logic        load_en;
   logic [31:0] load_instr;
   logic [31:0] load_pc;
   logic [31:0] br_pc;

   assign br_pc = exec_br_target_i & ~32'd3;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      kill_d       = kill_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      hold_valid_d = hold_valid_q;
      req          = 1'b0;
      load_en      = 1'b0;
      load_instr   = imem.imem_rdata_i;
      load_pc      = req_pc_q;

      unique case (state_q)
         S_REQ: begin
            req = 1'b1;
            if (exec_br_taken_i) begin
               pc_d = br_pc;
               // The granted fetch was for the old path; its response must be dropped.
               if (imem.imem_gnt_i) begin
                  state_d = S_WAIT;
                  kill_d  = 1'b1;
               end
            end else if (imem.imem_gnt_i) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!imem.imem_rvalid_i) begin
               if (exec_br_taken_i) begin
                  pc_d   = br_pc;
                  kill_d = 1'b1;
               end
            end else if (exec_br_taken_i || kill_q) begin
               if (exec_br_taken_i) pc_d = br_pc;
               kill_d  = 1'b0;
               state_d = S_REQ;
            end else if (stall_i) begin
               hold_instr_d = imem.imem_rdata_i;
               hold_pc_d    = req_pc_q;
               hold_valid_d = 1'b1;
               state_d      = S_HOLD;
            end else begin
               // Back-to-back: deliver this response and issue the next fetch together.
               load_en = 1'b1;
               req     = 1'b1;
               if (imem.imem_gnt_i) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            load_instr = hold_instr_q;
            load_pc    = hold_pc_q;
            if (exec_br_taken_i) begin
               pc_d         = br_pc;
               hold_valid_d = 1'b0;
               state_d      = S_REQ;
            end else if (!stall_i) begin
               load_en      = hold_valid_q;
               hold_valid_d = 1'b0;
               state_d      = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = pc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_REQ;
         pc_q         <= BOOT_ADDR;
         req_pc_q     <= 32'd0;
         kill_q       <= 1'b0;
         hold_instr_q <= 32'd0;
         hold_pc_q    <= 32'd0;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   // Redirect outranks stall: the decode register is flushed even while decode is stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dec_instr_o  <= NOP_INSTR;
         dec_pc_o     <= 32'd0;
         dec_pcplus_o <= 32'd0;
      end else if (exec_br_taken_i) begin
         dec_instr_o  <= NOP_INSTR;
         dec_pc_o     <= 32'd0;
         dec_pcplus_o <= 32'd0;
      end else if (load_en) begin
         dec_instr_o  <= load_instr;
         dec_pc_o     <= load_pc;
         dec_pcplus_o <= load_pc + 32'd4;
      end else if (!stall_i) begin
         dec_instr_o  <= NOP_INSTR;
         dec_pc_o     <= 32'd0;
         dec_pcplus_o <= 32'd0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] instr_cnt_q;
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_cnt_q  <= 32'd0;
         bubble_cnt_q <= 32'd0;
      end else begin
         if (load_en && !exec_br_taken_i) instr_cnt_q <= instr_cnt_q + 32'd1;
         if (exec_br_taken_i || (!load_en && !stall_i)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign perf_instr_cnt_o  = instr_cnt_q;
   assign perf_bubble_cnt_o = bubble_cnt_q;
`else
   assign perf_instr_cnt_o  = 32'd0;
   assign perf_bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle checks plus a scoreboard of expected decode loads.
// Perf-counter expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_stage;

   localparam logic [31:0] Nop = 32'h0000_0013;

`ifdef FETCH_PERF_CNT_EN
   localparam logic [31:0] ExpInstrCnt  = 32'd3;
   localparam logic [31:0] ExpBubbleCnt = 32'd2;
`else
   localparam logic [31:0] ExpInstrCnt  = 32'd0;
   localparam logic [31:0] ExpBubbleCnt = 32'd0;
`endif

   logic        clk_i;
   logic        rst_i;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        gnt_val;
   int unsigned lat;

   logic [31:0] a_instr, a_pc, a_pcplus, a_perf_instr, a_perf_bubble;
   logic [31:0] b_instr, b_pc, b_pcplus, b_perf_instr, b_perf_bubble;

   int n_checks;
   int n_errors;

   logic [63:0] sb_q[$];
   logic [63:0] prev_out;

   logic        pend;
   int unsigned cnt;
   logic [31:0] gaddr;

   fetch_stage_if aif ();
   fetch_stage_if bif ();

   fetch_stage #(.BOOT_ADDR(32'h0000_1000), .NOP_INSTR(Nop)) dut_a (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .imem             (aif),
      .stall_i          (stall),
      .exec_br_taken_i  (br_taken),
      .exec_br_target_i (br_target),
      .dec_instr_o      (a_instr),
      .dec_pc_o         (a_pc),
      .dec_pcplus_o     (a_pcplus),
      .perf_instr_cnt_o (a_perf_instr),
      .perf_bubble_cnt_o(a_perf_bubble)
   );

   fetch_stage #(.BOOT_ADDR(32'hFFFF_FFFC), .NOP_INSTR(Nop)) dut_b (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .imem             (bif),
      .stall_i          (1'b0),
      .exec_br_taken_i  (1'b0),
      .exec_br_target_i (32'd0),
      .dec_instr_o      (b_instr),
      .dec_pc_o         (b_pc),
      .dec_pcplus_o     (b_pcplus),
      .perf_instr_cnt_o (b_perf_instr),
      .perf_bubble_cnt_o(b_perf_bubble)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1010) return 32'h0050_0093;
      return (a ^ 32'h5A5A_A5A5) | 32'h3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #2;
   endtask

   task automatic expect_load(input logic [31:0] pc);
      sb_q.push_back({mem_word(pc), pc});
   endtask

   // Memory for dut_a: grant driven by the bench, response after lat cycles.
   assign aif.imem_gnt_i = gnt_val;

   always @(posedge clk_i) begin
      aif.imem_rvalid_i <= 1'b0;
      if (aif.imem_req_o && aif.imem_gnt_i) begin
         if (lat == 1) begin
            aif.imem_rvalid_i <= 1'b1;
            aif.imem_rdata_i  <= mem_word(aif.imem_addr_o);
         end else begin
            pend  <= 1'b1;
            cnt   <= lat - 1;
            gaddr <= aif.imem_addr_o;
         end
      end else if (pend) begin
         if (cnt == 1) begin
            aif.imem_rvalid_i <= 1'b1;
            aif.imem_rdata_i  <= mem_word(gaddr);
            pend              <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end else if (rst_i) begin
         pend <= 1'b0;
      end
   end

   // Memory for dut_b: always grants, answers one cycle later.
   assign bif.imem_gnt_i = 1'b1;

   always @(posedge clk_i) begin
      bif.imem_rvalid_i <= bif.imem_req_o;
      bif.imem_rdata_i  <= mem_word(bif.imem_addr_o);
   end

   // Scoreboard: each new non-bubble decode word must match the oldest expected load.
   always @(negedge clk_i) begin
      if (!rst_i && a_instr !== Nop && {a_instr, a_pc} !== prev_out) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_extra_load", 32'(sb_q.size()), 32'd1);
         end else begin
            check_eq("sb_instr", a_instr, sb_q[0][63:32]);
            check_eq("sb_pc", a_pc, sb_q[0][31:0]);
            check_eq("sb_pcplus", a_pcplus, sb_q[0][31:0] + 32'd4);
            void'(sb_q.pop_front());
         end
      end
      prev_out <= {a_instr, a_pc};
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      pend      = 1'b0;
      cnt       = 0;
      gaddr     = 32'd0;
      prev_out  = 64'd0;
      rst_i     = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'd0;
      gnt_val   = 1'b1;
      lat       = 1;

      for (int i = 0; i < 5; i++) expect_load(32'h0000_1000 + 32'(4 * i));

      // Grants during reset leave a response landing in the first post-reset cycle.
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b0;

      @(negedge clk_i); // c0
      check_eq("rst_req", 32'(aif.imem_req_o), 32'd1);
      check_eq("rst_addr", aif.imem_addr_o, 32'h0000_1000);
      check_eq("rst_instr", a_instr, Nop);
      check_eq("rst_pc", a_pc, 32'd0);
      check_eq("rst_pcplus", a_pcplus, 32'd0);
      check_eq("rst_perf_instr", a_perf_instr, 32'd0);
      check_eq("rst_perf_bubble", a_perf_bubble, 32'd0);

      next_cycle(); // c1
      @(negedge clk_i);
      check_eq("c1_instr_nop", a_instr, Nop);
      check_eq("wrap_second_addr", bif.imem_addr_o, 32'd0);

      next_cycle(); // c2
      @(negedge clk_i);
      check_eq("stream_pc0", a_pc, 32'h0000_1000);
      check_eq("stream_pcplus0", a_pcplus, 32'h0000_1004);
      check_eq("wrap_first_pc", b_pc, 32'hFFFF_FFFC);
      check_eq("wrap_first_pcplus", b_pcplus, 32'd0);

      next_cycle(); // c3
      @(negedge clk_i);
      check_eq("stream_pc1", a_pc, 32'h0000_1004);
      check_eq("wrap_second_pc", b_pc, 32'd0);
      check_eq("wrap_second_pcplus", b_pcplus, 32'd4);

      next_cycle(); // c4
      @(negedge clk_i);
      check_eq("stream_pc2", a_pc, 32'h0000_1008);
      check_eq("stream_pcplus2", a_pcplus, 32'h0000_100C);

      // Response for 0x1010 arrives while decode is stalled for three cycles.
      for (int i = 0; i < 3; i++) begin
         next_cycle(); // c5..c7
         stall   = 1'b1;
         gnt_val = 1'b0;
         @(negedge clk_i);
         check_eq("stall_req", 32'(aif.imem_req_o), 32'd0);
         check_eq("stall_pc_hold", a_pc, 32'h0000_100C);
         check_eq("stall_instr_hold", a_instr, mem_word(32'h0000_100C));
      end

      next_cycle(); // c8
      stall = 1'b0;
      @(negedge clk_i);
      check_eq("hold_release_req", 32'(aif.imem_req_o), 32'd0);

      next_cycle(); // c9
      lat     = 3;
      gnt_val = 1'b1;
      @(negedge clk_i);
      check_eq("held_instr", a_instr, 32'h0050_0093);
      check_eq("held_pc", a_pc, 32'h0000_1010);
      check_eq("post_hold_addr", aif.imem_addr_o, 32'h0000_1014);

      // Redirect while the fetch of 0x1014 is outstanding.
      next_cycle(); // c10
      gnt_val   = 1'b0;
      br_taken  = 1'b1;
      br_target = 32'h0000_2003;
      @(negedge clk_i);

      next_cycle(); // c11
      br_taken = 1'b0;
      @(negedge clk_i);
      check_eq("redir_bubble_instr", a_instr, Nop);
      check_eq("redir_bubble_pc", a_pc, 32'd0);

      next_cycle(); // c12
      @(negedge clk_i);
      check_eq("kill_rvalid_seen", 32'(aif.imem_rvalid_i), 32'd1);
      check_eq("kill_no_req", 32'(aif.imem_req_o), 32'd0);

      next_cycle(); // c13
      @(negedge clk_i);
      check_eq("redir_req", 32'(aif.imem_req_o), 32'd1);
      check_eq("redir_addr", aif.imem_addr_o, 32'h0000_2000);
      check_eq("redir_discard", a_instr, Nop);

      // Fresh reset, then exactly 3 instructions and 2 unstalled bubbles.
      next_cycle();
      rst_i   = 1'b1;
      gnt_val = 1'b0;
      stall   = 1'b1;
      lat     = 1;
      next_cycle();
      for (int i = 0; i < 3; i++) expect_load(32'h0000_1000 + 32'(4 * i));
      next_cycle();
      rst_i   = 1'b0;
      gnt_val = 1'b1;
      @(negedge clk_i); // c0
      check_eq("perf_rst_instr", a_perf_instr, 32'd0);
      check_eq("perf_rst_bubble", a_perf_bubble, 32'd0);

      next_cycle(); // c1
      stall = 1'b0;
      next_cycle(); // c2
      next_cycle(); // c3
      gnt_val = 1'b0;
      next_cycle(); // c4
      next_cycle(); // c5
      next_cycle(); // c6
      stall = 1'b1;
      @(negedge clk_i);
      check_eq("perf_instr", a_perf_instr, ExpInstrCnt);
      check_eq("perf_bubble", a_perf_bubble, ExpBubbleCnt);
      check_eq("perf_final_instr", a_instr, Nop);

      repeat (3) next_cycle();
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
